arb_pry_lock: RTL
=================

# arb_pry_lock

Packet-aware round-robin arbiter that shares one valid/ready output channel between `WIDTH` requesters. Each cycle it selects a requester with a rotating-priority one-hot grant. It then steers that requester's data through a priority-select multiplexer, and holds the grant until the packet's last beat. It sits in front of shared datapath resources (bus ports, FIFOs, processing units) that must see whole packets without interleaving.

## Interface
- `DAT_T`, `logic [8-1:0]`, payload data type
- `WIDTH`, `4`, number of requesters (≥2)

- `clk`  input  1  clock, all logic on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `req_vld`  input  WIDTH  per-requester beat valid
- `req_lst`  input  WIDTH  per-requester last beat of packet
- `req_dat`  input  DAT_T [WIDTH-1:0]  per-requester payload array
- `req_rdy`  output  WIDTH  per-requester ready; only the granted bit may be 1
- `out_vld`  output  1  output beat valid
- `out_lst`  output  1  output last beat
- `out_dat`  output  DAT_T  output payload
- `out_rdy`  input  1  output ready from shared resource
- `gnt`  output  WIDTH  current one-hot grant (all-zero when nothing selected)
- `lck`  output  1  grant locked mid-packet

## Operation
- Transfer on any channel = vld & rdy in the same cycle.
- Pointer `ptr` (log2 WIDTH bits) holds the index of the last requester that completed a packet.
- States:
  - **IDLE**: `lck`=0.
    - Grant = first set bit of `req_vld` at indices above `ptr` (ascending). If there is none, grant = lowest set bit of `req_vld` overall.
    - Grant is combinational from `req_vld` and `ptr`.
  - **BUSY**: `lck`=1. Grant comes from the registered `gnt_q` and ignores other requesters.
- Transitions:
  - IDLE→BUSY on a transfer with `req_lst`=0; `gnt_q` captures the grant.
  - BUSY→IDLE on a transfer with `lst`=1.
  - IDLE→IDLE on a transfer with `lst`=1 (single-beat packet).
- `ptr` updates to the granted index on every transfer with `lst`=1, and only then.
- Datapath:
  - `out_dat`/`out_lst` = priority-select of `req_dat`/`req_lst` by `gnt`.
  - `out_vld` = |(`gnt` & `req_vld`).
  - `req_rdy` = `gnt` & {WIDTH{`out_rdy`}}.
- BUSY with granted `req_vld`=0: `out_vld`=0 and the grant is held. This is a bubble inside the packet; no switch occurs.
- No requests in IDLE: `gnt`=0, `out_vld`=0, `out_dat` don't-care.
- `ptr` wrap-around: at `ptr`=WIDTH-1 the search set above `ptr` is empty, so the lowest set bit wins.

## Timing
- Reset values: state IDLE, `ptr`=WIDTH-1 (index 0 has top priority first), `gnt_q`=0, `lck`=0, `out_vld`=0, `req_rdy`=0, `gnt`=0.
- Without the macro, latency is 0 cycles: the input beat appears on the output in the same cycle.
- Throughput is one beat per cycle. Back-to-back packets from different requesters need no idle cycle.
- Reset asserted mid-packet: the next cycle is IDLE and the partial packet is abandoned; the requester must restart.
- `rst` overrides all other events in the same cycle.
- Requesters must hold `req_vld`/`req_dat`/`req_lst` stable until transfer. A request dropping in IDLE before transfer may change the grant.

## Configuration
- `ARB_PRY_LOCK_OUT_REG_EN`
  - **Defined**: inserts a pipeline register on `out_vld`/`out_lst`/`out_dat`.
    - Latency is 1 cycle.
    - Register loads when empty or `out_rdy`=1.
    - Upstream ready becomes `gnt` & {WIDTH{~out_vld_q | out_rdy}}, so full throughput is kept.
    - Arbiter state and `ptr` advance on the upstream transfer.
    - `out_vld` resets to 0.
  - **Undefined**: purely combinational data path as above.

## Test plan
- Reset, then `req_vld`=4'b1111, all `lst`=1, `out_rdy`=1 for 8 cycles → `gnt` sequence 0001,0010,0100,1000,0001,… with `out_vld`=1 every cycle.
- Requester 2 sends 3-beat packet (lst on beat 3) while req 0,1 are valid → `gnt`=0100 for 3 transfers, `lck`=1 after beat 1, then `gnt`=1000→0001 order resumes (ptr=2, so next is 3 if valid, else 0).
- `out_rdy`=0 for 5 cycles mid-packet → `req_rdy`=0, `gnt` unchanged, no beat lost/duplicated; transfer completes when `out_rdy`=1.
- Granted requester deasserts `req_vld` for 2 cycles mid-packet while others request → `out_vld`=0 for 2 cycles, `gnt` held, `lck`=1.
- `rst` pulsed during BUSY beat 2 of a 4-beat packet → next cycle `lck`=0, `gnt` recomputed with `ptr`=WIDTH-1, `out_vld` reflects new grant.
- With `ARB_PRY_LOCK_OUT_REG_EN`: single request, `req_dat`=8'hA5, `lst`=1 → `out_dat`=8'hA5 with `out_vld`=1 exactly 1 cycle later. A continuous stream with `out_rdy`=1 gives one beat per cycle.

Source files
------------

// File: rtl/arb_pry_lock.sv
// arb_pry_lock: packet-aware round-robin arbiter.
// Shares one valid/ready output channel between WIDTH requesters and holds
// the grant from the first beat of a packet until its last beat.
// Optional output pipeline register: define ARB_PRY_LOCK_OUT_REG_EN.
//
// state | meaning
// IDLE  | no packet in flight, grant recomputed each cycle from req_vld/ptr
// BUSY  | packet in flight, grant held in gnt_q until the last beat
module arb_pry_lock #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       req_vld,
  input  logic [WIDTH-1:0]       req_lst,
  input  DAT_T [WIDTH-1:0]       req_dat,
  output logic [WIDTH-1:0]       req_rdy,
  output logic                   out_vld,
  output logic                   out_lst,
  output DAT_T                   out_dat,
  input  logic                   out_rdy,
  output logic [WIDTH-1:0]       gnt,
  output logic                   lck
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] gnt_q;
  logic [WIDTH-1:0] gnt_arb;
  logic [PW-1:0]    gnt_idx;
  logic             found;
  DAT_T             sel_dat;
  logic             sel_lst;
  logic             sel_vld;
  logic             up_rdy;
  logic             xfer;

  // Rotating priority: first requester above ptr, else lowest requester.
  always_comb begin
    gnt_arb = '0;
    found   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && req_vld[i] && (i > int'(ptr))) begin
        gnt_arb[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && req_vld[i]) begin
        gnt_arb[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Grant source: live arbitration in IDLE, held grant in BUSY; reset blanks it.
  always_comb begin
    if (rst)
      gnt = '0;
    else if (state == BUSY)
      gnt = gnt_q;
    else
      gnt = gnt_arb;
  end

  // Priority-select of the granted requester's beat and its index.
  always_comb begin
    sel_dat = '0;
    sel_lst = 1'b0;
    gnt_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (gnt[i]) begin
        sel_dat = req_dat[i];
        sel_lst = req_lst[i];
        gnt_idx = PW'(i);
      end
    end
  end

  assign sel_vld = |(gnt & req_vld);
  assign req_rdy = gnt & {WIDTH{up_rdy}};
  assign xfer    = sel_vld & up_rdy;

`ifdef ARB_PRY_LOCK_OUT_REG_EN
  logic out_vld_q;
  logic out_lst_q;
  DAT_T out_dat_q;

  assign up_rdy  = ~out_vld_q | out_rdy;
  assign out_vld = out_vld_q;
  assign out_lst = out_lst_q;
  assign out_dat = out_dat_q;

  // Output stage loads whenever it is empty or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_lst_q <= 1'b0;
      out_dat_q <= '0;
    end else if (up_rdy) begin
      out_vld_q <= sel_vld;
      out_lst_q <= sel_lst;
      out_dat_q <= sel_dat;
    end
  end
`else
  assign up_rdy  = out_rdy;
  assign out_vld = sel_vld;
  assign out_lst = sel_lst;
  assign out_dat = sel_dat;
`endif

  // Packet lock FSM and round-robin pointer, both advanced on upstream transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= PW'(WIDTH - 1);
      gnt_q <= '0;
      lck   <= 1'b0;
    end else if (xfer) begin
      if (sel_lst) begin
        state <= IDLE;
        ptr   <= gnt_idx;
        gnt_q <= '0;
        lck   <= 1'b0;
      end else begin
        state <= BUSY;
        gnt_q <= gnt;
        lck   <= 1'b1;
      end
    end
  end

endmodule
